// File: rtl/control_pipe_pkg.sv
// Shared opcode, ALU-op and write-back codes plus the stage control-word layouts for control_pipe.
// Build option CTRL_ILLEGAL_TRAP_EN (see control_pipe.sv) uses is_illegal() below.
package control_pipe_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam int REG_WIDTH    = 6;
  localparam int ALUOP_WIDTH  = 3;
  localparam int WB_WIDTH     = 2;

  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_INC    = 4'h5;
  localparam logic [3:0] OP_NEG    = 4'h6;
  localparam logic [3:0] OP_SUB    = 4'h7;
  localparam logic [3:0] OP_JUMP   = 4'h8;
  localparam logic [3:0] OP_BRZ    = 4'h9;
  localparam logic [3:0] OP_JMEM   = 4'hA;
  localparam logic [3:0] OP_BRN    = 4'hB;
  localparam logic [3:0] OP_LOAD   = 4'hE;
  localparam logic [3:0] OP_SAVEPC = 4'hF;

  localparam logic [ALUOP_WIDTH-1:0] ALU_NONE = 3'b000;
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = 3'b100;
  localparam logic [ALUOP_WIDTH-1:0] ALU_NEG  = 3'b010;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = 3'b001;

  localparam logic [WB_WIDTH-1:0] WB_PC  = 2'b00;
  localparam logic [WB_WIDTH-1:0] WB_MEM = 2'b01;
  localparam logic [WB_WIDTH-1:0] WB_ALU = 2'b10;

  // Full control word as it leaves decode and sits in ID/EX; all-zero is a bubble.
  typedef struct packed {
    logic [ALUOP_WIDTH-1:0] alu_op;
    logic                   alu_src;
    logic                   br_zero;
    logic                   br_neg;
    logic                   jump;
    logic                   jump_mem;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_wrt;
    logic [WB_WIDTH-1:0]    wb_sel;
  } ctrl_word_t;

  typedef struct packed {
    logic                mem_read;
    logic                mem_write;
    logic                reg_wrt;
    logic [WB_WIDTH-1:0] wb_sel;
  } mem_stage_t;

  typedef struct packed {
    logic                reg_wrt;
    logic [WB_WIDTH-1:0] wb_sel;
  } wb_stage_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'hC) || (op == 4'hD);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode -> control word decoder; unknown and illegal opcodes decode as noop.
module control_decode
  import control_pipe_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_word_t word
);

  always_comb begin
    word = '0;
    case (opcode)
      OP_SAVEPC: begin
        word.reg_wrt = 1'b1;
        word.wb_sel  = WB_PC;
      end
      OP_LOAD: begin
        word.mem_read = 1'b1;
        word.reg_wrt  = 1'b1;
        word.wb_sel   = WB_MEM;
      end
      OP_STORE: word.mem_write = 1'b1;
      OP_ADD: begin
        word.alu_op  = ALU_ADD;
        word.reg_wrt = 1'b1;
        word.wb_sel  = WB_ALU;
      end
      OP_INC: begin
        word.alu_op  = ALU_ADD;
        word.alu_src = 1'b1;
        word.reg_wrt = 1'b1;
        word.wb_sel  = WB_ALU;
      end
      OP_NEG: begin
        word.alu_op  = ALU_NEG;
        word.reg_wrt = 1'b1;
        word.wb_sel  = WB_ALU;
      end
      OP_SUB: begin
        word.alu_op  = ALU_SUB;
        word.reg_wrt = 1'b1;
        word.wb_sel  = WB_ALU;
      end
      OP_JUMP: word.jump = 1'b1;
      OP_BRZ: begin
        word.alu_op  = ALU_SUB;
        word.br_zero = 1'b1;
      end
      OP_BRN: word.br_neg = 1'b1;
      // jumpMem reads its target from memory but never writes a register.
      OP_JMEM: begin
        word.mem_read = 1'b1;
        word.jump     = 1'b1;
        word.jump_mem = 1'b1;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB; load-use stall and EX flush.
// Build option CTRL_ILLEGAL_TRAP_EN: adds a sticky illegalOp flag; undefined ties illegalOp to 0.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_WIDTH,
  parameter int REG_W    = REG_WIDTH,
  parameter int ALUOP_W  = ALUOP_WIDTH,
  parameter int WB_W     = WB_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idValid,
  input  logic [OPCODE_W-1:0] idOpcode,
  input  logic [REG_W-1:0]    idRd,
  input  logic [REG_W-1:0]    idRs,
  input  logic [REG_W-1:0]    idRt,
  input  logic                exFlush,
  output logic                stall,
  output logic [ALUOP_W-1:0]  exAluOp,
  output logic                exAluSrc,
  output logic                exBranchZero,
  output logic                exBranchNeg,
  output logic                exJump,
  output logic                exJumpMem,
  output logic                memRead,
  output logic                memWrite,
  output logic                wbRegWrt,
  output logic [WB_W-1:0]     wbCtrl,
  output logic [REG_W-1:0]    wbRd,
  output logic                illegalOp
);

  ctrl_word_t dec_word;
  ctrl_word_t id_word;
  ctrl_word_t ex_q;
  mem_stage_t mem_q;
  wb_stage_t  wb_q;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] mem_rd;
  logic [REG_W-1:0] wb_rd;
  logic ex_load;
  logic accept;

  control_decode u_decode (
    .opcode (idOpcode[3:0]),
    .word   (dec_word)
  );

  // Handshake: ID offers an instruction with idValid; it is taken on the edge where
  // accept = idValid & ~stall & ~exFlush. While stall is high upstream holds ID unchanged.
  assign ex_load = ex_q.mem_read & ~ex_q.jump_mem;
  assign stall   = idValid & ex_load & ~exFlush & ((ex_rd == idRs) | (ex_rd == idRt));
  assign accept  = idValid & ~stall & ~exFlush;

  always_comb begin
    id_word = '0;
    if (accept) id_word = dec_word;
  end

  // EX/MEM and MEM/WB advance unconditionally; only ID/EX sees bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      ex_rd  <= '0;
      mem_q  <= '0;
      mem_rd <= '0;
      wb_q   <= '0;
      wb_rd  <= '0;
    end else begin
      ex_q   <= id_word;
      ex_rd  <= accept ? idRd : '0;
      mem_q  <= '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                  reg_wrt: ex_q.reg_wrt, wb_sel: ex_q.wb_sel};
      mem_rd <= ex_rd;
      wb_q   <= '{reg_wrt: mem_q.reg_wrt, wb_sel: mem_q.wb_sel};
      wb_rd  <= mem_rd;
    end
  end

  assign exAluOp      = ALUOP_W'(ex_q.alu_op);
  assign exAluSrc     = ex_q.alu_src;
  assign exBranchZero = ex_q.br_zero;
  assign exBranchNeg  = ex_q.br_neg;
  assign exJump       = ex_q.jump;
  assign exJumpMem    = ex_q.jump_mem;
  assign memRead      = mem_q.mem_read;
  assign memWrite     = mem_q.mem_write;
  assign wbRegWrt     = wb_q.reg_wrt;
  assign wbCtrl       = WB_W'(wb_q.wb_sel);
  assign wbRd         = wb_rd;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else if (accept && is_illegal(idOpcode[3:0])) illegal_q <= 1'b1;
  end

  assign illegalOp = illegal_q;
`else
  assign illegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: reset, stream latency, load-use stall, flush, jumpMem, illegal opcode.
module tb_control_pipe;

  logic       clk;
  logic       rst;
  logic       idValid;
  logic [3:0] idOpcode;
  logic [5:0] idRd;
  logic [5:0] idRs;
  logic [5:0] idRt;
  logic       exFlush;
  logic       stall;
  logic [2:0] exAluOp;
  logic       exAluSrc;
  logic       exBranchZero;
  logic       exBranchNeg;
  logic       exJump;
  logic       exJumpMem;
  logic       memRead;
  logic       memWrite;
  logic       wbRegWrt;
  logic [1:0] wbCtrl;
  logic [5:0] wbRd;
  logic       illegalOp;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic exp_ill = 1'b1;
`else
  localparam logic exp_ill = 1'b0;
`endif

  control_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .idValid      (idValid),
    .idOpcode     (idOpcode),
    .idRd         (idRd),
    .idRs         (idRs),
    .idRt         (idRt),
    .exFlush      (exFlush),
    .stall        (stall),
    .exAluOp      (exAluOp),
    .exAluSrc     (exAluSrc),
    .exBranchZero (exBranchZero),
    .exBranchNeg  (exBranchNeg),
    .exJump       (exJump),
    .exJumpMem    (exJumpMem),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .wbRegWrt     (wbRegWrt),
    .wbCtrl       (wbCtrl),
    .wbRd         (wbRd),
    .illegalOp    (illegalOp)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] rd,
                       input logic [5:0] rs, input logic [5:0] rt, input logic fl);
    idValid  = v;
    idOpcode = op;
    idRd     = rd;
    idRs     = rs;
    idRt     = rt;
    exFlush  = fl;
  endtask

  task automatic idle;
    drive(1'b0, 4'h0, 6'd0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset_stall", stall, 0);
    chk("reset_exaluop", exAluOp, 0);
    chk("reset_memread", memRead, 0);
    chk("reset_wbregwrt", wbRegWrt, 0);
    chk("reset_illegal", illegalOp, 0);
    rst = 1'b0;
    tick();

    // add rd=3, sub, inc streamed without hazards
    drive(1'b1, 4'h4, 6'd3, 6'd1, 6'd2, 1'b0);
    #1 chk("add_nostall", stall, 0);
    tick();
    chk("add_ex_aluop", exAluOp, 3'b100);
    chk("add_ex_alusrc", exAluSrc, 0);
    drive(1'b1, 4'h7, 6'd4, 6'd1, 6'd2, 1'b0);
    tick();
    chk("sub_ex_aluop", exAluOp, 3'b001);
    chk("add_mem_read", memRead, 0);
    chk("add_mem_write", memWrite, 0);
    drive(1'b1, 4'h5, 6'd6, 6'd6, 6'd0, 1'b0);
    tick();
    chk("inc_ex_aluop", exAluOp, 3'b100);
    chk("inc_ex_alusrc", exAluSrc, 1);
    chk("add_wb_regwrt", wbRegWrt, 1);
    chk("add_wb_ctrl", wbCtrl, 2'b10);
    chk("add_wb_rd", wbRd, 6'd3);

    // store reaches MEM one cycle after EX
    drive(1'b1, 4'h3, 6'd0, 6'd1, 6'd2, 1'b0);
    tick();
    chk("store_ex_aluop", exAluOp, 0);
    idle();
    tick();
    chk("store_mem_write", memWrite, 1);
    tick();
    tick();

    // load rd=5 then add rs=5: one stall cycle
    drive(1'b1, 4'hE, 6'd5, 6'd1, 6'd2, 1'b0);
    tick();
    drive(1'b1, 4'h4, 6'd7, 6'd5, 6'd1, 1'b0);
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble_aluop", exAluOp, 0);
    chk("lu_load_memread", memRead, 1);
    chk("lu_stall_released", stall, 0);
    tick();
    chk("lu_add_in_ex", exAluOp, 3'b100);
    chk("lu_load_wbctrl", wbCtrl, 2'b01);
    chk("lu_load_wbrd", wbRd, 6'd5);
    idle();
    tick();
    tick();

    // brz in EX, flush: ID/EX bubbled
    drive(1'b1, 4'h9, 6'd0, 6'd1, 6'd2, 1'b0);
    tick();
    chk("brz_ex_branchzero", exBranchZero, 1);
    chk("brz_ex_aluop", exAluOp, 3'b001);
    drive(1'b1, 4'h4, 6'd9, 6'd1, 6'd2, 1'b1);
    tick();
    chk("flush_bubble_aluop", exAluOp, 0);
    chk("flush_bubble_brz", exBranchZero, 0);

    // load in EX, dependent op in ID, flush: stall forced off
    drive(1'b1, 4'hE, 6'd5, 6'd1, 6'd2, 1'b0);
    tick();
    drive(1'b1, 4'h4, 6'd7, 6'd5, 6'd5, 1'b1);
    #1 chk("flush_kills_stall", stall, 0);
    tick();
    chk("flush_lu_bubble", exAluOp, 0);
    chk("flush_lu_load_mem", memRead, 1);
    idle();
    tick();
    tick();

    // jumpMem rd=8 then add rs=8: no stall, no writeback
    drive(1'b1, 4'hA, 6'd8, 6'd1, 6'd2, 1'b0);
    tick();
    chk("jm_ex_jump", exJump, 1);
    chk("jm_ex_jumpmem", exJumpMem, 1);
    drive(1'b1, 4'h4, 6'd9, 6'd8, 6'd0, 1'b0);
    #1 chk("jm_nostall", stall, 0);
    tick();
    chk("jm_mem_read", memRead, 1);
    chk("jm_add_in_ex", exAluOp, 3'b100);
    idle();
    tick();
    chk("jm_wb_regwrt", wbRegWrt, 0);
    tick();
    chk("jm_add_wb_regwrt", wbRegWrt, 1);
    chk("jm_add_wb_rd", wbRd, 6'd9);

    // idValid=0 with a matching source behind a load: bubble, no stall
    drive(1'b1, 4'hE, 6'd5, 6'd1, 6'd2, 1'b0);
    tick();
    drive(1'b0, 4'h4, 6'd7, 6'd5, 6'd5, 1'b0);
    #1 chk("invalid_nostall", stall, 0);
    tick();
    chk("invalid_bubble", exAluOp, 0);
    idle();
    tick();
    tick();

    // illegal opcode C: noop controls, sticky flag when enabled
    drive(1'b1, 4'hC, 6'd10, 6'd1, 6'd2, 1'b0);
    tick();
    chk("ill_ex_aluop", exAluOp, 0);
    chk("ill_ex_jump", exJump, 0);
    chk("ill_flag", illegalOp, exp_ill);
    idle();
    tick();
    tick();
    chk("ill_wb_regwrt", wbRegWrt, 0);
    chk("ill_flag_held", illegalOp, exp_ill);

    // reset mid-stream with loads in flight
    drive(1'b1, 4'hE, 6'd5, 6'd1, 6'd2, 1'b0);
    tick();
    drive(1'b1, 4'hE, 6'd6, 6'd3, 6'd4, 1'b0);
    tick();
    chk("pre_rst_memread", memRead, 1);
    rst = 1'b1;
    #1;
    chk("rst_memread", memRead, 0);
    chk("rst_wbrd", wbRd, 0);
    chk("rst_illegal", illegalOp, 0);
    chk("rst_stall", stall, 0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_memread", memRead, 0);
    chk("post_rst_wbregwrt", wbRegWrt, 0);
    chk("post_rst_wbctrl", wbCtrl, 0);
    chk("post_rst_illegal", illegalOp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
